ibus16_capture: RTL



---
 rtl/ibus16_capture_pkg.sv | 15 +
 rtl/ibus16_capture_sync_ff.sv | 30 +++
 rtl/ibus16_capture.sv | 107 ++++++++++
 3 files changed

// File: rtl/ibus16_capture_pkg.sv
// Shared defaults and event-channel state encoding for ibus16_capture.
// Holds bus width, synchronizer depth, and filter length defaults.
package ibus16_capture_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SYNC_DEF  = 2;
  localparam int FILT_DEF  = 4;
  localparam int CNT_W_DEF = 3;

  typedef enum logic {
    EVT_IDLE = 1'b0,
    EVT_PEND = 1'b1
  } evt_state_e;

endpackage

// File: rtl/ibus16_capture_sync_ff.sv
// WIDTH x STAGES flop chain that brings an asynchronous bus into clk.
// Ports: clk, rst_n (async, active-low), d (raw), q (last stage).
module sync_ff
  import ibus16_capture_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STAGES = SYNC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/ibus16_capture.sv
// Captures an async pin bus: sync, glitch filter, change events.
// Ports: din_i/en_i in; data_o, chg_pulse_o, evt_* valid/ready, ovf_o.
module ibus16_capture
  import ibus16_capture_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_DEF,
  parameter int FILT_LEN    = FILT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] data_o,
  output logic             chg_pulse_o,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [WIDTH-1:0] evt_data_o,
  output logic [WIDTH-1:0] evt_prev_o,
  output logic             ovf_o,
  input  logic             ovf_clr_i
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;
  logic             upd;
  logic             ovf_set;
  evt_state_e       state;

  sync_ff #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (din_i),
    .q     (s)
  );

  // cand has been seen FILT_LEN times in a row and differs from data_o.
  assign upd = en_i && (cnt == CNT_MAX) && (cand != data_o);

  // Overwrite of an unaccepted event; a same-cycle transfer is not loss.
  assign ovf_set = (state == EVT_PEND) && upd && !evt_ready_i;

  assign evt_valid_o = (state == EVT_PEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand        <= '0;
      cnt         <= '0;
      data_o      <= '0;
      chg_pulse_o <= 1'b0;
    end else begin
      chg_pulse_o <= upd;
      if (upd) begin
        data_o <= cand;
      end
      if (!en_i) begin
        cnt <= '0;
      end else if (s != cand) begin
        cand <= s;
        cnt  <= CNT_ONE;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EVT_IDLE;
      evt_data_o <= '0;
      evt_prev_o <= '0;
      ovf_o      <= 1'b0;
    end else begin
      unique case (state)
        EVT_IDLE: begin
          if (upd) begin
            state      <= EVT_PEND;
            evt_data_o <= cand;
            evt_prev_o <= data_o;
          end
        end
        EVT_PEND: begin
          if (upd) begin
            evt_data_o <= cand;
            evt_prev_o <= data_o;
          end else if (evt_ready_i) begin
            state <= EVT_IDLE;
          end
        end
      endcase
      if (ovf_set) begin
        ovf_o <= 1'b1;
      end else if (ovf_clr_i) begin
        ovf_o <= 1'b0;
      end
    end
  end

endmodule
